// File: rtl/gray_conv_sched_pkg.sv
// Shared types and constants for the gray converter scheduler.
package gray_conv_sched_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned EN_W   = 3;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Converter modes, forwarded verbatim from the requester
  localparam logic [MODE_W-1:0] MODE_B2G = 2'b00;
  localparam logic [MODE_W-1:0] MODE_G2B = 2'b01;

  // Converter enable word when no conversion is in flight
  localparam logic [EN_W-1:0] EN_OFF = 3'b000;

  // Latched request payload
  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] data;
  } conv_req_t;

endpackage

// File: rtl/converter_gray.sv
// Combinational binary/gray converter; en_i = {enable, mode}.
module converter_gray
  import gray_conv_sched_pkg::*;
(
  input  logic [EN_W-1:0]   en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Output is zero when disabled; undefined modes pass data through
  always_comb begin
    data_o = '0;
    if (en_i[EN_W-1]) begin
      case (en_i[MODE_W-1:0])
        MODE_B2G: data_o = data_i ^ (data_i >> 1);
        MODE_G2B: begin
          for (int unsigned s = 0; s < DATA_W; s++) begin
            data_o = data_o ^ (data_i >> s);
          end
        end
        default:  data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/gray_conv_sched_arb.sv
// Round-robin pick: first asserted request at or after ptr_i, wrapping.
module gray_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  int unsigned     cand;
  logic [ID_W-1:0] cand_idx;

  // Scan candidates in priority order starting at the pointer
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = ID_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one converter_gray between N_REQ requesters.
module gray_conv_sched
  import gray_conv_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [DATA_W*N_REQ-1:0] req_data_i,
  input  logic [MODE_W*N_REQ-1:0] req_mode_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic                  busy_o
);

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  conv_req_t       req_q;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_valid;
  logic [ID_W-1:0]   rr_ptr_next;
  conv_req_t         sel_req;
  logic [EN_W-1:0]   conv_en;
  logic [DATA_W-1:0] conv_data_in;
  logic [DATA_W-1:0] conv_data_out;

  gray_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // Grant is only offered while idle and out of reset
  assign req_ready_o = (state_q == S_IDLE && rst_ni) ? gnt : '0;

  // Pointer moves just past the winner, wrapping at N_REQ-1
  assign rr_ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Mux the winner's operand and mode
  always_comb begin
    sel_req = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_req = {req_mode_i[MODE_W*k +: MODE_W], req_data_i[DATA_W*k +: DATA_W]};
      end
    end
  end

  // Converter is driven only from registered state and idles at EN_OFF
  assign conv_en      = (state_q == S_CONV) ? {1'b1, req_q.mode} : EN_OFF;
  assign conv_data_in = (state_q == S_CONV) ? req_q.data : '0;

  converter_gray u_conv (
    .en_i   (conv_en),
    .data_i (conv_data_in),
    .data_o (conv_data_out)
  );

  // Scheduler FSM with registered response and busy outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      req_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            req_q    <= sel_req;
            id_q     <= gnt_idx;
            rr_ptr_q <= rr_ptr_next;
            busy_o   <= 1'b1;
            state_q  <= S_CONV;
          end
        end
        S_CONV: begin
          rsp_data_o  <= conv_data_out;
          rsp_id_o    <= id_q;
          rsp_valid_o <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_sched.sv
// Randomized self-checking bench for gray_conv_sched against a transaction-level model.
module tb_gray_conv_sched;

  localparam int N = 4;

  logic        clk;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [31:0] req_data_i;
  logic [7:0]  req_mode_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [7:0]  rsp_data_o;
  logic [1:0]  rsp_id_o;
  logic        busy_o;

  gray_conv_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_mode_i  (req_mode_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side view: pending requests
  logic [3:0] v;
  logic [7:0] d [N];
  logic [1:0] m [N];
  int         model_ptr = 0;
  bit         rand_arrive = 0;
  bit         keep_all = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: gray encode is d^(d>>1); gray decode bit i is parity of bits [7:i]
  function automatic logic [7:0] ref_conv(input logic [7:0] x, input logic [1:0] md);
    logic [7:0] r;
    if (md == 2'b00) return x ^ (x >> 1);
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = ^(x >> i);
    return r;
  endfunction

  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      if (v[(model_ptr + i) % N]) return (model_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int k);
    if (k < 0) return 4'b0000;
    return 4'(1 << k);
  endfunction

  task automatic drive();
    req_valid_i = v;
    for (int k = 0; k < N; k++) begin
      req_data_i[8*k +: 8] = d[k];
      req_mode_i[2*k +: 2] = m[k];
    end
  endtask

  task automatic new_req(input int k);
    v[k] = 1'b1;
    d[k] = 8'($urandom);
    m[k] = 2'($urandom_range(0, 1));
  endtask

  // New requests only appear on idle requesters; pending ones are held
  task automatic refill();
    for (int k = 0; k < N; k++) begin
      if (!v[k]) begin
        if (keep_all) new_req(k);
        else if (rand_arrive && $urandom_range(0, 2) == 0) new_req(k);
      end
    end
  endtask

  task automatic ensure_pending();
    if ((rand_arrive || keep_all) && v == 4'b0000) new_req($urandom_range(0, N - 1));
  endtask

  // One full transaction starting in IDLE; bp = extra cycles of rsp_ready_i low
  task automatic serve_one(input int bp, output int k);
    logic [7:0] ed;
    logic [1:0] em;
    @(negedge clk);
    check_eq("rsp_idle", 32'(rsp_valid_o), 0);
    check_eq("busy_idle", 32'(busy_o), 0);
    check_eq("en_idle", 32'(dut.conv_en), 0);
    k = model_pick();
    check_eq("grant", 32'(req_ready_o), 32'(onehot(k)));
    if (k < 0) k = 0;
    ed = ref_conv(d[k], m[k]);
    em = m[k];
    model_ptr = (k + 1) % N;
    rsp_ready_i = (bp == 0);
    @(posedge clk); #1;
    v[k] = 1'b0;
    refill(); drive();
    @(negedge clk);
    check_eq("conv_rsp_low", 32'(rsp_valid_o), 0);
    check_eq("conv_busy", 32'(busy_o), 1);
    check_eq("conv_ready", 32'(req_ready_o), 0);
    check_eq("conv_en", 32'(dut.conv_en), 32'({1'b1, em}));
    @(posedge clk); #1;
    refill(); drive();
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid_o), 1);
    check_eq("rsp_data", 32'(rsp_data_o), 32'(ed));
    check_eq("rsp_id", 32'(rsp_id_o), 32'(k));
    check_eq("resp_busy", 32'(busy_o), 1);
    check_eq("resp_ready", 32'(req_ready_o), 0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (i == bp - 1) rsp_ready_i = 1'b1;
      refill(); drive();
      @(negedge clk);
      check_eq("bp_valid", 32'(rsp_valid_o), 1);
      check_eq("bp_data", 32'(rsp_data_o), 32'(ed));
      check_eq("bp_id", 32'(rsp_id_o), 32'(k));
      check_eq("bp_busy", 32'(busy_o), 1);
      check_eq("bp_ready", 32'(req_ready_o), 0);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'($urandom_range(0, 1));
    refill(); ensure_pending(); drive();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    model_ptr = 0;
  endtask

  int got;

  initial begin
    rst_ni      = 1'b0;
    rsp_ready_i = 1'b0;
    v           = '0;
    for (int k = 0; k < N; k++) begin d[k] = '0; m[k] = '0; end
    drive();

    // Reset with random inputs: everything quiet
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      v = 4'($urandom);
      for (int k = 0; k < N; k++) begin d[k] = 8'($urandom); m[k] = 2'($urandom); end
      rsp_ready_i = 1'($urandom);
      drive();
      @(negedge clk);
      check_eq("rst_rsp_valid", 32'(rsp_valid_o), 0);
      check_eq("rst_rsp_data", 32'(rsp_data_o), 0);
      check_eq("rst_rsp_id", 32'(rsp_id_o), 0);
      check_eq("rst_busy", 32'(busy_o), 0);
      check_eq("rst_ready", 32'(req_ready_o), 0);
      check_eq("rst_en", 32'(dut.conv_en), 0);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    v = '0;
    drive();
    @(negedge clk);
    check_eq("idle_no_req_ready", 32'(req_ready_o), 0);
    check_eq("idle_no_req_busy", 32'(busy_o), 0);

    // Single bin->gray request from requester 0
    @(posedge clk); #1;
    v = 4'b0001; d[0] = 8'h05; m[0] = 2'b00;
    drive();
    serve_one(0, got);
    check_eq("t2_id", 32'(got), 0);

    // Gray->bin request from requester 2
    v = 4'b0100; d[2] = 8'h07; m[2] = 2'b01;
    drive();
    serve_one(0, got);
    check_eq("t3_id", 32'(got), 2);

    // Fairness: all requesters continuously valid from a fresh pointer
    do_reset();
    keep_all = 1;
    refill(); drive();
    for (int i = 0; i < 5; i++) begin
      serve_one(0, got);
      check_eq("fair_order", 32'(got), 32'(i % N));
    end

    // Backpressure for 5 cycles in RESP
    serve_one(5, got);

    // Random traffic with random backpressure
    keep_all = 0;
    rand_arrive = 1;
    ensure_pending(); drive();
    for (int t = 0; t < 40; t++) begin
      serve_one($urandom_range(0, 3), got);
    end

    // Reset while a conversion is in flight
    keep_all = 1;
    refill(); drive();
    @(negedge clk);
    check_eq("mf_grant", 32'(req_ready_o), 32'(onehot(model_pick())));
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    check_eq("mf_rsp_valid", 32'(rsp_valid_o), 0);
    check_eq("mf_busy", 32'(busy_o), 0);
    @(negedge clk);
    check_eq("mf_en", 32'(dut.conv_en), 0);
    check_eq("mf_ready", 32'(req_ready_o), 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    model_ptr = 0;
    v = 4'b1111;
    drive();
    serve_one(0, got);
    check_eq("mf_restart_id", 32'(got), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
